// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift left, parallel load, shift right on one WIDTH-bit register.
// One clock per operation; p_out is the register itself, s_out is combinational from q and mode only.
module universal_shift_register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             s_in,
    input  logic [WIDTH-1:0] p_in,
    output logic             s_out,
    output logic [WIDTH-1:0] p_out
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHL   = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b10;
    localparam logic [1:0] MODE_SHR   = 2'b11;

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (mode)
                MODE_HOLD: q <= q;
                MODE_SHL:  q <= {q[WIDTH-2:0], s_in};
                MODE_LOAD: q <= p_in;
                MODE_SHR:  q <= {s_in, q[WIDTH-1:1]};
                default:   q <= q;
            endcase
        end
    end

    // s_out shows the bit that the next shift in the selected direction will drop.
    assign s_out = (mode == MODE_SHR) ? q[0] : q[WIDTH-1];
    assign p_out = q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed and random stimulus for universal_shift_register (WIDTH=4) with a queue scoreboard.
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       s_in;
    logic [3:0] p_in;
    logic       s_out;
    logic [3:0] p_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] p;
        logic       s;
        string      tag;
    } exp_t;

    exp_t sb[$];
    logic [3:0] mq;

    universal_shift_register #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .s_in  (s_in),
        .p_in  (p_in),
        .s_out (s_out),
        .p_out (p_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_next(input logic r, input logic [1:0] m,
                                              input logic si, input logic [3:0] pi,
                                              input logic [3:0] cur);
        if (r) return 4'b0000;
        case (m)
            2'b00:   return cur;
            2'b01:   return {cur[2:0], si};
            2'b10:   return pi;
            default: return {si, cur[3:1]};
        endcase
    endfunction

    function automatic logic model_sout(input logic [1:0] m, input logic [3:0] cur);
        return (m == 2'b11) ? cur[0] : cur[3];
    endfunction

    // Drive one edge, push the expected result, then pop and compare after the edge.
    task automatic step(input string tag, input logic r, input logic [1:0] m, input logic si,
                        input logic [3:0] pi, input logic [3:0] exp_p, input logic exp_s);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = r; mode = m; s_in = si; p_in = pi;
        e.p = exp_p; e.s = exp_s; e.tag = tag;
        sb.push_back(e);
        #1;
        if (!$isunknown(mq))
            chk({tag, "_sout_pre"}, {3'b000, s_out}, {3'b000, model_sout(m, mq)});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            got = sb.pop_front();
            chk({got.tag, "_pout"}, p_out, got.p);
            chk({got.tag, "_sout"}, {3'b000, s_out}, {3'b000, got.s});
        end
        mq = exp_p;
    endtask

    initial begin
        logic [3:0] nq;
        logic [1:0] rm;
        logic       rs;
        logic       rr;
        logic [3:0] rp;
        logic [3:0] held_p;
        logic       held_s;

        mq = 4'bxxxx;
        rst = 1'b0; mode = 2'b00; s_in = 1'b0; p_in = 4'b0000;

        // Reset with a load pending must still clear
        step("reset",      1'b1, 2'b10, 1'b0, 4'b1111, 4'b0000, 1'b0);
        step("load1101",   1'b0, 2'b10, 1'b0, 4'b1101, 4'b1101, 1'b1);
        step("hold",       1'b0, 2'b00, 1'b1, 4'b0000, 4'b1101, 1'b1);
        step("shl_s1",     1'b0, 2'b01, 1'b1, 4'b0000, 4'b1011, 1'b1);
        step("shl_s0",     1'b0, 2'b01, 1'b0, 4'b0000, 4'b0110, 1'b0);
        step("shr_s1a",    1'b0, 2'b11, 1'b1, 4'b0000, 4'b1011, 1'b1);
        step("shr_s1b",    1'b0, 2'b11, 1'b1, 4'b0000, 4'b1101, 1'b1);

        step("load1000",   1'b0, 2'b10, 1'b0, 4'b1000, 4'b1000, 1'b1);
        for (int i = 0; i < 4; i++)
            step($sformatf("flush%0d", i), 1'b0, 2'b01, 1'b0, 4'b1111, 4'b0000, 1'b0);

        step("load1111",   1'b0, 2'b10, 1'b0, 4'b1111, 4'b1111, 1'b1);
        step("mid_rst",    1'b1, 2'b11, 1'b1, 4'b1111, 4'b0000, 1'b0);
        step("after_rst",  1'b0, 2'b11, 1'b1, 4'b0000, 4'b1000, 1'b0);

        // Inputs wiggling between edges must not reach q or s_out
        held_p = p_out;
        held_s = s_out;
        @(negedge clk);
        p_in = ~p_in; s_in = ~s_in;
        #1;
        chk("between_edge_pout", p_out, held_p);
        chk("between_edge_sout", {3'b000, s_out}, {3'b000, held_s});
        rst = 1'b1;
        #1;
        chk("rst_no_async", p_out, held_p);
        @(posedge clk);
        #1;
        mq = 4'b0000;
        chk("rst_sync_clear", p_out, 4'b0000);

        for (int i = 0; i < 60; i++) begin
            rm = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 15) == 0);
            rp = 4'($urandom_range(0, 15));
            nq = model_next(rr, rm, rs, rp, mq);
            step($sformatf("rand%0d", i), rr, rm, rs, rp, nq, model_sout(rm, nq));
        end

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_drain: observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
